// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths, field positions and FSM states for the data-cache controller
package dcache_pkg;
  localparam int ADDR_W    = 32;
  localparam int LINE_W    = 256;
  localparam int INDEX_W   = 4;
  localparam int OFF_W     = 5;
  localparam int TAG_W     = ADDR_W - INDEX_W - OFF_W;
  localparam int WORD_W    = 32;
  localparam int WSEL_W    = 3;
  localparam int STAG_W    = TAG_W + 2;
  localparam int VALID_BIT = 24;
  localparam int DIRTY_BIT = 23;
  localparam int TAG_LSB   = INDEX_W + OFF_W;
  localparam int INDEX_LSB = OFF_W;
  localparam int WORD_LSB  = 2;
  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, READMISS, READMISSOK} state_t;
  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t, input logic [INDEX_W-1:0] i);
    return {t, i, {OFF_W{1'b0}}};
  endfunction
endpackage

// File: rtl/dcache_word_sel.sv
// dcache_word_sel: extract one 32-bit word from a line and build the line with that word replaced
module dcache_word_sel
  import dcache_pkg::*;
(
  input  logic [LINE_W-1:0] i_line,
  input  logic [WSEL_W-1:0] i_off,
  input  logic [WORD_W-1:0] i_word,
  output logic [WORD_W-1:0] o_word,
  output logic [LINE_W-1:0] o_line
);
  logic [7:0] w_base;
  assign w_base = {i_off, 5'b0};
  assign o_word = i_line[w_base +: WORD_W];
  // Merge: start from the stored line and overwrite only the addressed word
  always_comb begin
    o_line = i_line;
    o_line[w_base +: WORD_W] = i_word;
  end
endmodule

// File: rtl/dcache_controller.sv
// dcache_controller: CPU-side hit path and write-back/refill miss FSM in front of the cache SRAM
module dcache_controller
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WORD_W-1:0] cpu_data_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [WORD_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic [INDEX_W-1:0] sram_index_o,
  output logic [STAG_W-1:0] sram_tag_o,
  output logic [LINE_W-1:0] sram_data_o,
  output logic              sram_enable_o,
  output logic              sram_write_o,
  input  logic [STAG_W-1:0] sram_tag_i,
  input  logic [LINE_W-1:0] sram_data_i,
  input  logic              sram_hit_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);
  state_t              r_state;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [LINE_W-1:0]   r_mem_data;
  logic                r_mem_en;
  logic                r_mem_wr;
  logic [LINE_W-1:0]   r_refill;
  logic [WORD_W-1:0]   r_cpu_data;
  logic                w_req;
  logic                w_idle;
  logic                w_hit;
  logic                w_fill;
  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_index;
  logic [WSEL_W-1:0]   w_off;
  logic [WORD_W-1:0]   w_word;
  logic [LINE_W-1:0]   w_merged;
  logic                w_unused;
  assign w_req    = cpu_MemRead_i | cpu_MemWrite_i;
  assign w_tag    = cpu_addr_i[ADDR_W-1:TAG_LSB];
  assign w_index  = cpu_addr_i[TAG_LSB-1:INDEX_LSB];
  assign w_off    = cpu_addr_i[INDEX_LSB-1:WORD_LSB];
  assign w_unused = ^cpu_addr_i[WORD_LSB-1:0];
  assign w_idle   = r_state == IDLE;
  assign w_fill   = r_state == READMISSOK;
  assign w_hit    = w_idle & w_req & sram_hit_i;
  dcache_word_sel u_word_sel (
    .i_line(sram_data_i),
    .i_off (w_off),
    .i_word(cpu_data_i),
    .o_word(w_word),
    .o_line(w_merged)
  );
  assign sram_enable_o = w_req;
  assign sram_index_o  = w_index;
  assign cpu_stall_o   = w_req & (~w_idle | ~sram_hit_i);
  assign sram_write_o  = w_fill | (w_hit & cpu_MemWrite_i);
  assign sram_tag_o    = {1'b1, ~w_fill & cpu_MemWrite_i, w_tag};
  assign sram_data_o   = w_fill ? r_refill : w_merged;
  assign cpu_data_o    = (w_hit & ~cpu_MemWrite_i) ? w_word : r_cpu_data;
  assign mem_addr_o    = r_mem_addr;
  assign mem_data_o    = r_mem_data;
  assign mem_enable_o  = r_mem_en;
  assign mem_write_o   = r_mem_wr;
  // Miss FSM: pick write-back or refill, hold the memory request until ack, then fill the SRAM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_en   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_refill   <= '0;
      r_cpu_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req & ~sram_hit_i) r_state <= MISS;
          if (w_hit & ~cpu_MemWrite_i) r_cpu_data <= w_word;
        end
        MISS: begin
          r_mem_en <= 1'b1;
          if (sram_tag_i[VALID_BIT] & sram_tag_i[DIRTY_BIT]) begin
            r_mem_addr <= line_addr(sram_tag_i[TAG_W-1:0], w_index);
            r_mem_data <= sram_data_i;
            r_mem_wr   <= 1'b1;
            r_state    <= WRITEBACK;
          end else begin
            r_mem_addr <= line_addr(w_tag, w_index);
            r_mem_wr   <= 1'b0;
            r_state    <= READMISS;
          end
        end
        WRITEBACK: if (mem_ack_i) begin
          r_mem_addr <= line_addr(w_tag, w_index);
          r_mem_wr   <= 1'b0;
          r_state    <= READMISS;
        end
        READMISS: if (mem_ack_i) begin
          r_refill <= mem_data_i;
          r_mem_en <= 1'b0;
          r_state  <= READMISSOK;
        end
        READMISSOK: r_state <= IDLE;
        default:    r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: directed stimulus with scoreboard queues checked by an independent monitor
module tb_dcache_controller;
  import dcache_pkg::*;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [31:0] cpu_data_i = '0;
  logic [31:0] cpu_addr_i = '0;
  logic cpu_MemRead_i = 1'b0;
  logic cpu_MemWrite_i = 1'b0;
  logic [31:0] cpu_data_o;
  logic cpu_stall_o;
  logic [3:0] sram_index_o;
  logic [24:0] sram_tag_o;
  logic [255:0] sram_data_o;
  logic sram_enable_o;
  logic sram_write_o;
  logic [24:0] sram_tag_i;
  logic [255:0] sram_data_i;
  logic sram_hit_i;
  logic [31:0] mem_addr_o;
  logic [255:0] mem_data_o;
  logic mem_enable_o;
  logic mem_write_o;
  logic [255:0] mem_data_i;
  logic mem_ack_i;

  dcache_controller dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_data_i(cpu_data_i), .cpu_addr_i(cpu_addr_i),
    .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_index_o(sram_index_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
    .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic unexpected(input string name);
    total++;
    $display("FAIL %s: DUT output with no expected entry queued", name);
  endtask

  function automatic logic [255:0] mk(input logic [31:0] b);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = b + k;
    return l;
  endfunction

  typedef struct {logic [31:0] addr; logic wr; logic [255:0] data;} mem_t;
  typedef struct {logic [24:0] tag; logic [255:0] data;} wr_t;
  logic [31:0] cpu_q[$];
  mem_t mem_q[$];
  wr_t wr_q[$];

  // Two-way SRAM with one LRU bit per set; looks up by the tag field the controller presents
  logic [24:0] mtag [16][2] = '{default: '0};
  logic [255:0] mdat [16][2] = '{default: '0};
  logic mlru [16] = '{default: 1'b0};
  logic mway;
  always_comb begin
    logic h0, h1;
    h0 = mtag[sram_index_o][0][24] && mtag[sram_index_o][0][22:0] == sram_tag_o[22:0];
    h1 = mtag[sram_index_o][1][24] && mtag[sram_index_o][1][22:0] == sram_tag_o[22:0];
    sram_hit_i = h0 | h1;
    mway = h0 ? 1'b0 : h1 ? 1'b1 : mlru[sram_index_o];
    sram_tag_i = mtag[sram_index_o][mway];
    sram_data_i = mdat[sram_index_o][mway];
  end
  always @(posedge clk_i) begin
    if (sram_write_o) begin
      mtag[sram_index_o][mway] <= sram_tag_o;
      mdat[sram_index_o][mway] <= sram_data_o;
      mlru[sram_index_o] <= ~mway;
    end else if (sram_enable_o && sram_hit_i) mlru[sram_index_o] <= ~mway;
  end

  // Backing memory responding after lat cycles; force_ack injects a stray ack pulse
  logic hold = 1'b0;
  logic force_ack = 1'b0;
  int lat = 2;
  int cnt = 0;
  logic [255:0] bmem [logic [31:0]];
  initial begin
    logic [255:0] l;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    l = mk(32'h2000_0000);
    l[63:32] = 32'hDEAD_BEEF;
    bmem[32'h200] = l;
    bmem[32'h400] = mk(32'h4000_0000);
    bmem[32'h600] = mk(32'h6000_0000);
    forever begin
      @(negedge clk_i);
      if (force_ack) begin
        mem_ack_i = 1'b1;
        mem_data_i = {8{32'hBAD0_BAD0}};
      end else if (mem_ack_i || !mem_enable_o || hold || rst_i) begin
        mem_ack_i = 1'b0;
        cnt = 0;
      end else if (++cnt == lat) begin
        mem_ack_i = 1'b1;
        cnt = 0;
        if (mem_write_o) bmem[mem_addr_o] = mem_data_o;
        else mem_data_i = bmem.exists(mem_addr_o) ? bmem[mem_addr_o] : '0;
      end
    end
  end

  // Monitor: pop and compare whenever the DUT completes a load, writes the SRAM or issues a memory request
  logic p_en = 1'b0;
  logic p_wr = 1'b0;
  logic [31:0] p_addr = '0;
  int wb_cnt = 0;
  always @(negedge clk_i) begin
    logic [31:0] e;
    mem_t m;
    wr_t w;
    if (!rst_i) begin
      if (cpu_MemRead_i && !cpu_MemWrite_i && !cpu_stall_o) begin
        if (cpu_q.size() == 0) unexpected("cpu_load");
        else begin
          e = cpu_q.pop_front();
          chk("cpu_data", {224'b0, cpu_data_o}, {224'b0, e});
        end
      end
      if (sram_write_o) begin
        if (wr_q.size() == 0) unexpected("sram_write");
        else begin
          w = wr_q.pop_front();
          chk("sram_tag", {231'b0, sram_tag_o}, {231'b0, w.tag});
          chk("sram_data", sram_data_o, w.data);
        end
      end
      if (mem_enable_o && (!p_en || mem_addr_o != p_addr || mem_write_o != p_wr)) begin
        if (mem_q.size() == 0) unexpected("mem_req");
        else begin
          m = mem_q.pop_front();
          chk("mem_addr", {224'b0, mem_addr_o}, {224'b0, m.addr});
          chk("mem_write", {255'b0, mem_write_o}, {255'b0, m.wr});
          if (m.wr) chk("mem_data", mem_data_o, m.data);
        end
      end
    end
    if (mem_enable_o && mem_write_o && !(p_en && p_wr)) wb_cnt++;
    p_en = mem_enable_o;
    p_wr = mem_write_o;
    p_addr = mem_addr_o;
  end

  task automatic do_req(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] d, output int stalls);
    @(posedge clk_i); #1;
    cpu_addr_i = a;
    cpu_MemRead_i = rd;
    cpu_MemWrite_i = wr;
    cpu_data_i = d;
    stalls = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (!cpu_stall_o) break;
      stalls++;
    end
    chk("req_done", {255'b0, cpu_stall_o}, 256'd0);
    @(posedge clk_i); #1;
    cpu_MemRead_i = 1'b0;
    cpu_MemWrite_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int wb0;
    logic [255:0] l200, l600;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_cpu_data", {224'b0, cpu_data_o}, 256'd0);
    chk("rst_mem_en", {255'b0, mem_enable_o}, 256'd0);
    chk("rst_mem_wr", {255'b0, mem_write_o}, 256'd0);
    chk("rst_mem_addr", {224'b0, mem_addr_o}, 256'd0);
    chk("rst_mem_data", mem_data_o, 256'd0);
    chk("rst_stall", {255'b0, cpu_stall_o}, 256'd0);
    @(posedge clk_i); #1 rst_i = 1'b0;

    l200 = mk(32'h2000_0000);
    l200[63:32] = 32'hDEAD_BEEF;
    mem_q.push_back('{32'h200, 1'b0, '0});
    wr_q.push_back('{{2'b10, 23'h1}, l200});
    cpu_q.push_back(32'hDEAD_BEEF);
    do_req(32'h204, 1'b1, 1'b0, '0, s);
    chk("clean_miss_stalls", s, 5);

    l200[95:64] = 32'h1234_5678;
    wr_q.push_back('{{2'b11, 23'h1}, l200});
    do_req(32'h208, 1'b0, 1'b1, 32'h1234_5678, s);
    chk("store_hit_stalls", s, 0);

    wb0 = wb_cnt;
    mem_q.push_back('{32'h400, 1'b0, '0});
    wr_q.push_back('{{2'b10, 23'h2}, mk(32'h4000_0000)});
    cpu_q.push_back(32'h4000_0000);
    do_req(32'h400, 1'b1, 1'b0, '0, s);
    chk("clean_victim_stalls", s, 5);
    chk("clean_victim_no_wb", wb_cnt, wb0);

    mem_q.push_back('{32'h200, 1'b1, l200});
    mem_q.push_back('{32'h600, 1'b0, '0});
    wr_q.push_back('{{2'b10, 23'h3}, mk(32'h6000_0000)});
    cpu_q.push_back(32'h6000_0000);
    do_req(32'h600, 1'b1, 1'b0, '0, s);
    chk("dirty_wb_count", wb_cnt, wb0 + 1);
    chk("dirty_wb_bmem", bmem[32'h200], l200);

    cpu_q.push_back(32'h6000_0001);
    do_req(32'h604, 1'b1, 1'b0, '0, s);
    chk("read_hit_stalls", s, 0);
    l600 = mk(32'h6000_0000);
    l600[127:96] = 32'hCAFE_F00D;
    wr_q.push_back('{{2'b11, 23'h3}, l600});
    do_req(32'h60C, 1'b1, 1'b1, 32'hCAFE_F00D, s);
    chk("both_high_stalls", s, 0);

    hold = 1'b1;
    mem_q.push_back('{32'h800, 1'b0, '0});
    @(posedge clk_i); #1;
    cpu_addr_i = 32'h800;
    cpu_MemRead_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (mem_enable_o) break;
    end
    chk("rm_issue", {255'b0, mem_enable_o}, 256'd1);
    chk("rm_state", {253'b0, dut.r_state}, {253'b0, READMISS});
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    cpu_MemRead_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    force_ack = 1'b1;
    chk("rst_mid_state", {253'b0, dut.r_state}, {253'b0, IDLE});
    chk("rst_mid_mem_en", {255'b0, mem_enable_o}, 256'd0);
    @(negedge clk_i);
    @(posedge clk_i); #1 force_ack = 1'b0;
    @(negedge clk_i);
    chk("late_ack_no_write", {255'b0, sram_write_o}, 256'd0);
    chk("late_ack_state", {253'b0, dut.r_state}, {253'b0, IDLE});
    chk("late_ack_mem_en", {255'b0, mem_enable_o}, 256'd0);
    hold = 1'b0;

    cpu_q.push_back(32'hCAFE_F00D);
    do_req(32'h60C, 1'b1, 1'b0, '0, s);
    chk("post_rst_hit_stalls", s, 0);

    repeat (3) @(posedge clk_i);
    chk("cpu_q_left", cpu_q.size(), 0);
    chk("mem_q_left", mem_q.size(), 0);
    chk("wr_q_left", wr_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
